// File: rtl/mips_pkg.sv
// Shared definitions for the pipelined MIPS core: widths, ALU encodings,
// the control bundle carried through the pipeline registers, and stage actions.
package mips_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int ALU_CTRL_W = 3;

    typedef enum logic [ALU_CTRL_W-1:0] {
        ALU_AND = 3'b000,
        ALU_OR  = 3'b001,
        ALU_ADD = 3'b010,
        ALU_SUB = 3'b110,
        ALU_SLT = 3'b111
    } alu_op_e;

    // Decoded control bits; EX/MEM and MEM/WB carry the same bundle downstream.
    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic mem_write;
        logic alu_src;
        logic reg_dst;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    // What a pipeline register does on a given clock edge.
    typedef enum logic [1:0] {
        ACT_LOAD,
        ACT_HOLD,
        ACT_BUBBLE,
        ACT_FLUSH
    } stage_act_e;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector: flags an EX-stage load whose destination (rt) is
// read by the instruction in ID. Purely combinational; shared with forwarding.
module load_use_detect
    import mips_pkg::*;
#(
    parameter int ADDR_WIDTH = REG_ADDR_W
) (
    input  logic [ADDR_WIDTH-1:0] rs_i,
    input  logic [ADDR_WIDTH-1:0] rt_i,
    input  logic [ADDR_WIDTH-1:0] ex_rt,
    input  logic                  ex_mem_to_reg,
    input  logic                  ex_valid,
    output logic                  hazard
);

    // $0 is hardwired to zero, so a load into it can never feed a consumer.
    assign hazard = ex_valid & ex_mem_to_reg & (ex_rt != '0) &
                    ((ex_rt == rs_i) | (ex_rt == rt_i));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion and IF/ID stall.
// Optional hazard-bubble counter output stall_cnt_o under `define STALL_CNT_EN.
module id_ex_stage
    import mips_pkg::*;
#(
    parameter int DATA_WIDTH     = DATA_W,
    parameter int ADDR_WIDTH     = REG_ADDR_W,
    parameter int ALU_CTRL_WIDTH = ALU_CTRL_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_WIDTH-1:0]     rd1_i,
    input  logic [DATA_WIDTH-1:0]     rd2_i,
    input  logic [DATA_WIDTH-1:0]     imm_i,
    input  logic [ADDR_WIDTH-1:0]     rs_i,
    input  logic [ADDR_WIDTH-1:0]     rt_i,
    input  logic [ADDR_WIDTH-1:0]     rd_i,
    input  logic                      reg_write_i,
    input  logic                      mem_to_reg_i,
    input  logic                      mem_write_i,
    input  logic                      alu_src_i,
    input  logic                      reg_dst_i,
    input  logic [ALU_CTRL_WIDTH-1:0] alu_ctrl_i,
    input  logic                      flush_i,
    input  logic                      hold_i,
    output logic [DATA_WIDTH-1:0]     rd1_o,
    output logic [DATA_WIDTH-1:0]     rd2_o,
    output logic [DATA_WIDTH-1:0]     imm_o,
    output logic [ADDR_WIDTH-1:0]     rs_o,
    output logic [ADDR_WIDTH-1:0]     rt_o,
    output logic [ADDR_WIDTH-1:0]     rd_o,
    output logic                      reg_write_o,
    output logic                      mem_to_reg_o,
    output logic                      mem_write_o,
    output logic                      alu_src_o,
    output logic                      reg_dst_o,
    output logic [ALU_CTRL_WIDTH-1:0] alu_ctrl_o,
    output logic                      valid_o,
    output logic                      stall_o
`ifdef STALL_CNT_EN
    ,
    output logic [31:0]               stall_cnt_o
`endif
);

    ctrl_t      ctrl_d;
    ctrl_t      ctrl_q;
    logic       hazard;
    stage_act_e act;

    assign ctrl_d = '{reg_write:  reg_write_i,
                      mem_to_reg: mem_to_reg_i,
                      mem_write:  mem_write_i,
                      alu_src:    alu_src_i,
                      reg_dst:    reg_dst_i};

    load_use_detect #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_load_use_detect (
        .rs_i          (rs_i),
        .rt_i          (rt_i),
        .ex_rt         (rt_o),
        .ex_mem_to_reg (mem_to_reg_o),
        .ex_valid      (valid_o),
        .hazard        (hazard)
    );

    // A taken branch squashes the ID instruction, so it must not also freeze IF/ID.
    assign stall_o = (hazard & ~flush_i) | hold_i;

    // NOTE: act gets a default before the priority chain so no path leaves it unassigned (no latch).
    always_comb begin
        act = ACT_LOAD;
        if (flush_i)     act = ACT_FLUSH;
        else if (hold_i) act = ACT_HOLD;
        else if (hazard) act = ACT_BUBBLE;
    end

    // NOTE: nonblocking (<=) for all state so every flop samples pre-edge values;
    // every flop is async-reset because valid_o and control must be 0 out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd1_o      <= '0;
            rd2_o      <= '0;
            imm_o      <= '0;
            rs_o       <= '0;
            rt_o       <= '0;
            rd_o       <= '0;
            ctrl_q     <= CTRL_NOP;
            alu_ctrl_o <= '0;
            valid_o    <= 1'b0;
        end else begin
            unique case (act)
                ACT_FLUSH, ACT_BUBBLE: begin
                    rd1_o      <= '0;
                    rd2_o      <= '0;
                    imm_o      <= '0;
                    rs_o       <= '0;
                    rt_o       <= '0;
                    rd_o       <= '0;
                    ctrl_q     <= CTRL_NOP;
                    alu_ctrl_o <= '0;
                    valid_o    <= 1'b0;
                end
                ACT_LOAD: begin
                    rd1_o      <= rd1_i;
                    rd2_o      <= rd2_i;
                    imm_o      <= imm_i;
                    rs_o       <= rs_i;
                    rt_o       <= rt_i;
                    rd_o       <= rd_i;
                    ctrl_q     <= ctrl_d;
                    alu_ctrl_o <= alu_ctrl_i;
                    valid_o    <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign reg_write_o  = ctrl_q.reg_write;
    assign mem_to_reg_o = ctrl_q.mem_to_reg;
    assign mem_write_o  = ctrl_q.mem_write;
    assign alu_src_o    = ctrl_q.alu_src;
    assign reg_dst_o    = ctrl_q.reg_dst;

`ifdef STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    // Counts only load-use bubbles; flush bubbles and holds are not hazards.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else if (act == ACT_BUBBLE && stall_cnt_q != '1) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: reference model + scoreboard queue,
// directed load-use/flush/hold/reset cases, then a random instruction stream.
module tb_id_ex_stage;
    import mips_pkg::*;

    typedef struct packed {
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_to_reg;
        logic        mem_write;
        logic        alu_src;
        logic        reg_dst;
        logic [2:0]  alu_ctrl;
        logic        valid;
    } ex_t;

    logic clk;
    logic rst;
    ex_t  id;
    logic flush;
    logic hold;

    logic [31:0] rd1_o, rd2_o, imm_o;
    logic [4:0]  rs_o, rt_o, rd_o;
    logic        reg_write_o, mem_to_reg_o, mem_write_o, alu_src_o, reg_dst_o;
    logic [2:0]  alu_ctrl_o;
    logic        valid_o, stall_o;
`ifdef STALL_CNT_EN
    logic [31:0] stall_cnt_o;
`endif

    int n_vec;
    int n_err;

    ex_t         model;
    logic [31:0] model_cnt;
    ex_t         sb[$];

    id_ex_stage dut (
        .clk          (clk),
        .rst          (rst),
        .rd1_i        (id.rd1),
        .rd2_i        (id.rd2),
        .imm_i        (id.imm),
        .rs_i         (id.rs),
        .rt_i         (id.rt),
        .rd_i         (id.rd),
        .reg_write_i  (id.reg_write),
        .mem_to_reg_i (id.mem_to_reg),
        .mem_write_i  (id.mem_write),
        .alu_src_i    (id.alu_src),
        .reg_dst_i    (id.reg_dst),
        .alu_ctrl_i   (id.alu_ctrl),
        .flush_i      (flush),
        .hold_i       (hold),
        .rd1_o        (rd1_o),
        .rd2_o        (rd2_o),
        .imm_o        (imm_o),
        .rs_o         (rs_o),
        .rt_o         (rt_o),
        .rd_o         (rd_o),
        .reg_write_o  (reg_write_o),
        .mem_to_reg_o (mem_to_reg_o),
        .mem_write_o  (mem_write_o),
        .alu_src_o    (alu_src_o),
        .reg_dst_o    (reg_dst_o),
        .alu_ctrl_o   (alu_ctrl_o),
        .valid_o      (valid_o),
        .stall_o      (stall_o)
`ifdef STALL_CNT_EN
        ,
        .stall_cnt_o  (stall_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before 500000");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic ex_t observed();
        ex_t o;
        o = '{rd1: rd1_o, rd2: rd2_o, imm: imm_o, rs: rs_o, rt: rt_o, rd: rd_o,
              reg_write: reg_write_o, mem_to_reg: mem_to_reg_o, mem_write: mem_write_o,
              alu_src: alu_src_o, reg_dst: reg_dst_o, alu_ctrl: alu_ctrl_o, valid: valid_o};
        return o;
    endfunction

    function automatic ex_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                               input logic is_ld, input logic [31:0] d1, input logic [31:0] d2,
                               input logic [31:0] imm);
        ex_t e;
        e = '0;
        e.rd1 = d1; e.rd2 = d2; e.imm = imm;
        e.rs = rs; e.rt = rt; e.rd = rd;
        e.reg_write  = 1'b1;
        e.mem_to_reg = is_ld;
        e.alu_src    = is_ld;
        e.reg_dst    = ~is_ld;
        e.alu_ctrl   = is_ld ? ALU_ADD : ALU_SUB;
        e.valid      = 1'b1;
        return e;
    endfunction

    function automatic logic model_hazard(input ex_t in);
        return model.valid && model.mem_to_reg && model.rt != 5'd0 &&
               (model.rt == in.rs || model.rt == in.rt);
    endfunction

    // One clock: drive during the low phase, check stall_o, predict the edge, compare after it.
    task automatic step(input ex_t in, input logic fl, input logic hd, output logic again);
        logic hz;
        logic exp_stall;
        id = in; flush = fl; hold = hd;
        #1;
        hz = model_hazard(in);
        exp_stall = (hz && !fl) || hd;
        check("stall_o", {127'd0, stall_o}, {127'd0, exp_stall});
        if (fl) begin
            model = '0;
        end else if (hd) begin
            model = model;
        end else if (hz) begin
            model = '0;
            if (model_cnt != 32'hFFFF_FFFF) model_cnt = model_cnt + 32'd1;
        end else begin
            model = in;
            model.valid = 1'b1;
        end
        sb.push_back(model);
        @(posedge clk);
        #1;
        check("ex_regs", {8'd0, observed()}, {8'd0, sb.pop_front()});
`ifdef STALL_CNT_EN
        check("stall_cnt", {96'd0, stall_cnt_o}, {96'd0, model_cnt});
`endif
        again = exp_stall && !fl;
        @(negedge clk);
    endtask

    // Present an instruction until the stage accepts it (IF/ID re-presents on stall).
    task automatic issue(input ex_t in, input logic fl, input logic hd);
        logic again;
        int   tries;
        step(in, fl, hd, again);
        tries = 0;
        while (again && tries < 4) begin
            step(in, 1'b0, 1'b0, again);
            tries++;
        end
        if (again) check("issue_budget", 128'd1, 128'd0);
    endtask

    // Called right after a falling edge; reset pulse sits entirely inside the low phase.
    task automatic reset_pulse();
        hold = 1'b0; flush = 1'b0;
        #1 rst = 1'b0;
        #1;
        check("rst_async_regs", {8'd0, observed()}, 128'd0);
        check("rst_async_stall", {127'd0, stall_o}, 128'd0);
        model = '0;
        model_cnt = '0;
`ifdef STALL_CNT_EN
        check("rst_async_cnt", {96'd0, stall_cnt_o}, 128'd0);
`endif
        #1 rst = 1'b1;
    endtask

    ex_t  lw8, add9, lw0, add0, lw7, use7, ldbeef, nxt, r;
    logic dummy;

    initial begin
        n_vec = 0; n_err = 0;
        rst = 1'b0; id = '0; flush = 1'b0; hold = 1'b0;
        model = '0; model_cnt = '0;
        #3;
        check("reset_regs", {8'd0, observed()}, 128'd0);
        check("reset_valid", {127'd0, valid_o}, 128'd0);
        @(negedge clk);
        rst = 1'b1;

        // Mid-stream async reset, then normal load on the first edge after release
        issue(mk(5'd1, 5'd2, 5'd3, 1'b0, 32'h1234, 32'h55, 32'h0), 1'b0, 1'b0);
        check("pre_rst_rd1", {96'd0, rd1_o}, {96'd0, 32'h1234});
        reset_pulse();
        issue(mk(5'd4, 5'd5, 5'd6, 1'b0, 32'hA5A5_0001, 32'h2, 32'h3), 1'b0, 1'b0);
        check("post_rst_valid", {127'd0, valid_o}, 128'd1);

        // lw $8 followed by add $9,$8,$10: exactly one bubble
        lw8  = mk(5'd3, 5'd8, 5'd0, 1'b1, 32'h100, 32'h0, 32'h4);
        add9 = mk(5'd8, 5'd10, 5'd9, 1'b0, 32'h11, 32'h22, 32'h0);
        issue(lw8, 1'b0, 1'b0);
        step(add9, 1'b0, 1'b0, dummy);
        check("lu_bubble_valid", {127'd0, valid_o}, 128'd0);
        check("lu_bubble_rw", {127'd0, reg_write_o}, 128'd0);
        step(add9, 1'b0, 1'b0, dummy);
        check("lu_add_rs", {123'd0, rs_o}, {123'd0, 5'd8});
        check("lu_add_rw", {127'd0, reg_write_o}, 128'd1);

        // Load into $0 never stalls
        lw0  = mk(5'd2, 5'd0, 5'd0, 1'b1, 32'h200, 32'h0, 32'h8);
        add0 = mk(5'd0, 5'd4, 5'd5, 1'b0, 32'h0, 32'h44, 32'h0);
        issue(lw0, 1'b0, 1'b0);
        step(add0, 1'b0, 1'b0, dummy);
        check("lw0_no_bubble", {127'd0, valid_o}, 128'd1);

        // Hazard and flush together: no stall, bubble, counter untouched
        lw7  = mk(5'd1, 5'd7, 5'd0, 1'b1, 32'h300, 32'h0, 32'hC);
        use7 = mk(5'd6, 5'd7, 5'd2, 1'b0, 32'h66, 32'h77, 32'h0);
        issue(lw7, 1'b0, 1'b0);
        step(use7, 1'b1, 1'b0, dummy);
        check("flush_valid", {127'd0, valid_o}, 128'd0);

        // Hold for three cycles, then load after release
        ldbeef = mk(5'd9, 5'd11, 5'd12, 1'b0, 32'h1, 32'hDEAD_BEEF, 32'h2);
        nxt    = mk(5'd13, 5'd14, 5'd15, 1'b0, 32'h3, 32'h4, 32'h5);
        issue(ldbeef, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(nxt, 1'b0, 1'b1, dummy);
            check("hold_rd2", {96'd0, rd2_o}, {96'd0, 32'hDEAD_BEEF});
        end
        step(nxt, 1'b0, 1'b0, dummy);
        check("hold_release_rd2", {96'd0, rd2_o}, {96'd0, 32'h4});

`ifdef STALL_CNT_EN
        @(negedge clk);
        reset_pulse();
        for (int i = 0; i < 4; i++) begin
            issue(mk(5'd1, 5'(i + 16), 5'd0, 1'b1, 32'(i), 32'h0, 32'h0), 1'b0, 1'b0);
            issue(mk(5'(i + 16), 5'd2, 5'd3, 1'b0, 32'h9, 32'h8, 32'h0), 1'b0, 1'b0);
        end
        check("cnt_four", {96'd0, stall_cnt_o}, {96'd0, 32'd4});
        force dut.stall_cnt_q = 32'hFFFF_FFFE;
        #1 release dut.stall_cnt_q;
        model_cnt = 32'hFFFF_FFFE;
        for (int i = 0; i < 2; i++) begin
            issue(mk(5'd1, 5'd20, 5'd0, 1'b1, 32'h0, 32'h0, 32'h0), 1'b0, 1'b0);
            issue(mk(5'd20, 5'd2, 5'd3, 1'b0, 32'h0, 32'h0, 32'h0), 1'b0, 1'b0);
        end
        check("cnt_saturate", {96'd0, stall_cnt_o}, {96'd0, 32'hFFFF_FFFF});
`endif

        // Random stream over a small register set to provoke hazards
        for (int i = 0; i < 60; i++) begin
            r = mk(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   1'($urandom_range(0, 2) == 0), $urandom, $urandom, $urandom);
            r.mem_write = 1'($urandom_range(0, 1));
            r.alu_ctrl  = 3'($urandom_range(0, 7));
            issue(r, 1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 7) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register of the pipelined MIPS core.
- Sits directly downstream of the register file and decode. It captures RD1/RD2, the sign-extended immediate, the rs/rt/rd fields and the decoded control bits, and presents them to the EX stage.
- Owns load-use hazard detection. It inserts a one-cycle bubble and stalls IF/ID when an instruction in EX is a load whose destination is read in ID.

Parameters:
- DATA_WIDTH, 32, width of register data and immediate
- ADDR_WIDTH, 5, register-address width
- ALU_CTRL_WIDTH, 3, ALU control field width

Ports:
- clk  input  1  core clock; all state updates on rising edge
- rst  input  1  asynchronous active-low reset
- rd1_i  input  DATA_WIDTH  register-file read data port 1 (rs)
- rd2_i  input  DATA_WIDTH  register-file read data port 2 (rt)
- imm_i  input  DATA_WIDTH  sign-extended immediate
- rs_i / rt_i / rd_i  input  ADDR_WIDTH each  instruction register fields in ID
- reg_write_i, mem_to_reg_i, mem_write_i, alu_src_i, reg_dst_i  input  1 each  decoded control
- alu_ctrl_i  input  ALU_CTRL_WIDTH  ALU operation
- flush_i  input  1  branch/jump taken; squash the ID instruction
- hold_i  input  1  downstream freeze; EX not accepting
- rd1_o, rd2_o, imm_o, rs_o, rt_o, rd_o, plus all control signals with the _o suffix  output  matching widths  registered EX-stage copies
- valid_o  output  1  EX slot holds a real instruction
- stall_o  output  1  combinational; IF/ID and PC must hold this cycle

Behaviour:
- Reset (rst=0, async): all registered outputs go to 0, valid_o goes to 0, and the stall counter clears. Effect is immediate and independent of clk. This holds mid-operation; the first edge after release loads normally.
- Hazard (combinational) = valid_o & mem_to_reg_o & (rt_o != 0) & ((rt_o == rs_i) | (rt_o == rt_i)).
- stall_o = (hazard & ~flush_i) | hold_i.
- Each rising edge applies exactly one of the following, in priority order:
  1. flush_i=1: bubble. All control outputs, valid_o and all data/address outputs are loaded with 0. Flush wins over hold.
  2. hold_i=1: all outputs retain their values.
  3. hazard=1: bubble, same as a flush. The ID instruction is re-presented next cycle because stall_o held IF/ID.
  4. Otherwise: load all inputs and set valid_o=1.
- Latency: one cycle from ID to the outputs. A load-use pair costs exactly one bubble cycle. The second cycle sees a bubble in EX, so the hazard is 0.
- No write-back bypass is needed. The register file writes on the falling edge, so rd1_i/rd2_i already reflect a same-cycle write.
- A load targeting $0 never stalls.
- Field selection (reg_dst) is not resolved here. rt_o and rd_o are both forwarded.

Optional Feature:
- Macro: STALL_CNT_EN
- Defined:
  - Adds output stall_cnt_o [31:0].
  - Increments on every rising edge where a hazard bubble is inserted (case 3 only).
  - Saturates at 32'hFFFF_FFFF.
  - Cleared by reset.
- Undefined: no port and no counter logic. Behaviour is otherwise identical.

Decomposition:
- Shared package mips_pkg holds:
  - REG_ADDR_W=5 and the DATA_WIDTH default
  - the ALU control encodings (ADD, SUB, AND, OR, SLT)
  - the control-bundle field list, reused by the EX/MEM and MEM/WB stages
- One natural sub-module: load_use_detect. It is purely combinational: it takes rs_i, rt_i, rt_o, mem_to_reg_o and valid_o, and returns hazard. It is reused later by the forwarding unit.

Test Plan:
1. Assert rst low mid-stream with valid_o=1 and rd1_o=32'h1234 -> all outputs read 0 immediately, without a clk edge. After release, the next edge loads the inputs with valid_o=1.
2. lw $8 enters EX while add $9,$8,$10 is in ID -> stall_o=1 for one cycle, and the next edge gives valid_o=0 with all control 0. The edge after loads the add, with rs_o=8 and reg_write_o=1.
3. lw $0 in EX while add uses rs=0 in ID -> stall_o=0 and no bubble. The add loads on the next edge.
4. Load-use hazard present and flush_i=1 in the same cycle -> stall_o=0, bubble loaded, and no counter increment (STALL_CNT_EN).
5. hold_i=1 for 3 cycles with rd2_o=32'hDEAD_BEEF -> outputs constant and stall_o=1 throughout. The input loads on the cycle after hold_i drops.
6. STALL_CNT_EN defined, 4 separate load-use pairs -> stall_cnt_o=4. Preloading the counter near 32'hFFFF_FFFF via force followed by one more hazard -> the counter stays at 32'hFFFF_FFFF.
